// File: rtl/bist_pkg.sv
// Shared BIST definitions: ORA FSM state encoding and MISR defaults.
// Used by the output response analyzer and the pattern-generator checker.
package bist_pkg;

  localparam int BIST_WIDTH = 8;

  // x^8 + x^4 + x^3 + x^2 + 1, implicit x^8 term
  localparam logic [BIST_WIDTH-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/bist_misr_ora_if.sv
// Bus between the BIST controller / adder stage and the MISR output response analyzer.
// Handshake: result_in is captured on every rising clk edge where result_valid=1 while the
// analyzer is compacting; there is no ready, and the producer may idle result_valid for any
// number of cycles. start is a one-cycle pulse honoured only when busy=0.
interface bist_misr_ora_if
  import bist_pkg::*;
#(
  parameter int WIDTH = BIST_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] result_in;
  logic             result_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;

  // Controller / producer side
  modport master (
    output start,
    output result_in,
    output result_valid,
    input  busy,
    input  done,
    input  pass,
    input  signature
  );

  // Analyzer side
  modport slave (
    input  start,
    input  result_in,
    input  result_valid,
    output busy,
    output done,
    output pass,
    output signature
  );

endinterface

// File: rtl/bist_misr_ora_misr_step.sv
// Combinational MISR next-state function: shift left, fold POLY in on MSB carry-out, XOR data.
// Shared with the pattern-generator LFSR checker (data tied to zero there).
module misr_step
  import bist_pkg::*;
#(
  parameter int               WIDTH = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = MISR_POLY
) (
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] feedback;

  assign shifted  = {sig[WIDTH-2:0], 1'b0};
  assign feedback = sig[WIDTH-1] ? POLY : '0;
  assign next     = shifted ^ feedback ^ data;

endmodule

// File: rtl/bist_misr_ora.sv
// MISR output response analyzer: compacts PATTERNS products into a signature and checks it
// against GOLDEN. Optional abort input is built when BIST_ORA_ABORT_EN is defined.
module bist_misr_ora
  import bist_pkg::*;
#(
  parameter int               WIDTH    = BIST_WIDTH,
  parameter int               PATTERNS = 255,
  parameter logic [WIDTH-1:0] POLY     = MISR_POLY,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter logic [WIDTH-1:0] GOLDEN   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef BIST_ORA_ABORT_EN
  input  logic                 abort,
`endif
  bist_misr_ora_if.slave       bus,
  output state_t               state_dbg
);

  // Sized so PATTERNS itself is representable; the run ends at PATTERNS-1, so it never wraps.
  localparam int             CW   = $clog2(PATTERNS + 1);
  localparam logic [CW-1:0]  LAST = CW'(PATTERNS - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sig, sig_n;
  logic [CW-1:0]    count, count_n;
  logic             done_q, done_n;
  logic             pass_q, pass_n;
  logic [WIDTH-1:0] sig_step;
  logic             abort_req;

`ifdef BIST_ORA_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  misr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr_step (
    .sig  (sig),
    .data (bus.result_in),
    .next (sig_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sig    <= '0;
      count  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_n;
      sig    <= sig_n;
      count  <= count_n;
      done_q <= done_n;
      pass_q <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    sig_n   = sig;
    count_n = count;
    done_n  = done_q;
    pass_n  = pass_q;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          sig_n   = SEED;
          count_n = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          state_n = COMPACT;
        end
      end
      COMPACT: begin
        // Abort wins over a beat presented in the same cycle; the signature stays frozen.
        if (abort_req) begin
          done_n  = 1'b1;
          pass_n  = 1'b0;
          state_n = DONE;
        end else if (bus.result_valid) begin
          sig_n   = sig_step;
          count_n = count + CW'(1);
          if (count == LAST) begin
            state_n = COMPARE;
          end
        end
      end
      COMPARE: begin
        done_n  = 1'b1;
        pass_n  = abort_req ? 1'b0 : (sig == GOLDEN);
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy      = (state == COMPACT) || (state == COMPARE);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q & done_q;
  assign bus.signature = sig;
  assign state_dbg     = state;

endmodule

// File: tb/tb_bist_misr_ora.sv
// Bench for bist_misr_ora: directed runs on a 2-pattern instance, randomized runs on a
// 13-pattern instance, all outputs checked every cycle against a run-level reference model.
module tb_bist_misr_ora;
  import bist_pkg::*;

  localparam int PAT_A = 2;
  localparam int PAT_B = 13;
  localparam logic [7:0] SEED_A = 8'h00, GOLD_A = 8'h82;
  localparam logic [7:0] SEED_B = 8'h5A, GOLD_B = 8'hC3;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   abort_a = 1'b0;
  logic   abort_b = 1'b0;
  state_t st_a, st_b;

  int checks = 0;
  int failures = 0;

  bist_misr_ora_if #(.WIDTH(8)) ifa ();
  bist_misr_ora_if #(.WIDTH(8)) ifb ();

  always #5 clk = ~clk;

  bist_misr_ora #(.WIDTH(8), .PATTERNS(PAT_A), .POLY(8'h1D), .SEED(SEED_A), .GOLDEN(GOLD_A)) u_a (
    .clk       (clk),
    .rst       (rst),
`ifdef BIST_ORA_ABORT_EN
    .abort     (abort_a),
`endif
    .bus       (ifa.slave),
    .state_dbg (st_a)
  );

  bist_misr_ora #(.WIDTH(8), .PATTERNS(PAT_B), .POLY(8'h1D), .SEED(SEED_B), .GOLDEN(GOLD_B)) u_b (
    .clk       (clk),
    .rst       (rst),
`ifdef BIST_ORA_ABORT_EN
    .abort     (abort_b),
`endif
    .bus       (ifb.slave),
    .state_dbg (st_b)
  );

  // ---------------- reference model ----------------
  // Signature as polynomial arithmetic: multiply by x modulo x^8+x^4+x^3+x^2+1, add data.
  function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] d);
    logic [8:0] x;
    x = {s, 1'b0};
    if (x >= 9'd256) x = x ^ 9'h11D;
    return x[7:0] ^ d;
  endfunction

  // Per instance: whether a run is open, beats still owed, waiting for the verdict cycle.
  bit         m_running [2];
  bit         m_verdict [2];
  int         m_left    [2];
  logic [7:0] m_sig     [2];
  bit         m_done    [2];
  bit         m_pass    [2];
  int         m_pat     [2] = '{PAT_A, PAT_B};
  logic [7:0] m_seed    [2] = '{SEED_A, SEED_B};
  logic [7:0] m_gold    [2] = '{GOLD_A, GOLD_B};

  task automatic model_tick(input int i, input logic st, input logic v, input logic [7:0] d,
                            input logic ab);
    if (rst) begin
      m_running[i] = 0; m_verdict[i] = 0; m_left[i] = 0;
      m_sig[i] = 8'h00; m_done[i] = 0; m_pass[i] = 0;
    end else if (!m_running[i] && !m_verdict[i]) begin
      if (st) begin
        m_running[i] = 1; m_left[i] = m_pat[i];
        m_sig[i] = m_seed[i]; m_done[i] = 0; m_pass[i] = 0;
      end
    end else if (ab) begin
      m_running[i] = 0; m_verdict[i] = 0; m_done[i] = 1; m_pass[i] = 0;
    end else if (m_verdict[i]) begin
      m_verdict[i] = 0; m_done[i] = 1; m_pass[i] = (m_sig[i] == m_gold[i]);
    end else if (v) begin
      m_sig[i] = ref_step(m_sig[i], d);
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_running[i] = 0; m_verdict[i] = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each edge from the inputs that edge sees; outputs compared just after.
  always @(posedge clk) begin
    model_tick(0, ifa.start, ifa.result_valid, ifa.result_in, abort_a);
    model_tick(1, ifb.start, ifb.result_valid, ifb.result_in, abort_b);
    #1;
    chk("a_signature", 32'(ifa.signature), 32'(m_sig[0]));
    chk("a_busy", 32'(ifa.busy), 32'(m_running[0] || m_verdict[0]));
    chk("a_done", 32'(ifa.done), 32'(m_done[0]));
    chk("a_pass", 32'(ifa.pass), 32'(m_pass[0]));
    chk("b_signature", 32'(ifb.signature), 32'(m_sig[1]));
    chk("b_busy", 32'(ifb.busy), 32'(m_running[1] || m_verdict[1]));
    chk("b_done", 32'(ifb.done), 32'(m_done[1]));
    chk("b_pass", 32'(ifb.pass), 32'(m_pass[1]));
  end

  // ---------------- driver tasks ----------------
  task automatic nx();
    @(negedge clk);
  endtask

  task automatic a_drive(input logic st, input logic v, input logic [7:0] d);
    ifa.start = st; ifa.result_valid = v; ifa.result_in = d;
    nx();
  endtask

  task automatic a_expect(input string tag, input logic [7:0] sig, input logic dn, input logic ps);
    chk({tag, "_sig"}, 32'(ifa.signature), 32'(sig));
    chk({tag, "_done"}, 32'(ifa.done), 32'(dn));
    chk({tag, "_pass"}, 32'(ifa.pass), 32'(ps));
  endtask

  task automatic b_run(input bit force_pass, input bit rst_mid);
    int sent;
    int wait_n;
    logic [7:0] d;
    sent = 0;
    ifb.start = 1'b1; ifb.result_valid = 1'b0; nx();
    while (sent < PAT_B) begin
      ifb.start = ($urandom_range(0, 7) == 0);
      ifb.result_valid = ($urandom_range(0, 9) < 6);
      d = 8'($urandom_range(0, 255));
      if (ifb.result_valid && force_pass && sent == PAT_B - 1)
        d = ref_step(m_sig[1], 8'h00) ^ GOLD_B;
      ifb.result_in = d;
      if (ifb.result_valid) sent++;
      if (rst_mid && sent == 5) begin
        rst = 1'b1; nx(); rst = 1'b0;
        ifb.start = 1'b0; ifb.result_valid = 1'b0;
        return;
      end
      nx();
    end
    ifb.start = 1'b0; ifb.result_valid = 1'b0;
    wait_n = 0;
    while (!ifb.done && wait_n < 5) begin
      ifb.result_valid = $urandom_range(0, 1);
      ifb.result_in = 8'($urandom_range(0, 255));
      nx();
      wait_n++;
    end
    checks++;
    if (!ifb.done) begin
      failures++;
      $display("FAIL b_done_timeout actual=0 required=1 at %0t", $time);
    end
    repeat ($urandom_range(1, 4)) begin
      ifb.result_valid = $urandom_range(0, 1);
      ifb.result_in = 8'($urandom_range(0, 255));
      nx();
    end
    ifb.result_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifa.start = 0; ifa.result_valid = 0; ifa.result_in = 0;
    ifb.start = 0; ifb.result_valid = 0; ifb.result_in = 0;

    chk("ref_step_plain", 32'(ref_step(8'h01, 8'h80)), 32'h82);
    chk("ref_step_fb", 32'(ref_step(8'h80, 8'h00)), 32'h1D);

    nx(); nx();
    chk("rst_busy", 32'(ifa.busy), 32'h0);
    a_expect("rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic run: done/pass appear two edges after the last beat
    a_drive(1, 0, 8'h00);
    chk("start_busy", 32'(ifa.busy), 32'h1);
    a_drive(0, 1, 8'h01);
    a_drive(0, 1, 8'h80);
    a_expect("basic_cmp", 8'h82, 1'b0, 1'b0);
    a_drive(0, 0, 8'h00);
    a_expect("basic", 8'h82, 1'b1, 1'b1);
    a_drive(0, 1, 8'h55);
    a_expect("done_hold", 8'h82, 1'b1, 1'b1);

    // Feedback path
    a_drive(1, 0, 8'h00);
    chk("restart_done", 32'(ifa.done), 32'h0);
    a_drive(0, 1, 8'h80);
    a_drive(0, 1, 8'h00);
    a_drive(0, 0, 8'h00);
    a_expect("feedback", 8'h1D, 1'b1, 1'b0);

    // Gaps with a stray start mid-run
    a_drive(1, 0, 8'h00);
    a_drive(0, 1, 8'h01);
    a_drive(0, 0, 8'hFF);
    a_drive(1, 0, 8'hFF);
    a_drive(0, 0, 8'hFF);
    a_drive(0, 1, 8'h80);
    a_drive(0, 0, 8'h00);
    a_expect("gaps", 8'h82, 1'b1, 1'b1);

    // Reset mid-run, then a clean run
    a_drive(1, 0, 8'h00);
    a_drive(0, 1, 8'h01);
    rst = 1'b1; a_drive(0, 1, 8'h80); rst = 1'b0;
    a_expect("rst_mid", 8'h00, 1'b0, 1'b0);
    chk("rst_mid_busy", 32'(ifa.busy), 32'h0);
    a_drive(1, 0, 8'h00);
    a_drive(0, 1, 8'h01);
    a_drive(0, 1, 8'h80);
    a_drive(0, 0, 8'h00);
    a_expect("after_rst", 8'h82, 1'b1, 1'b1);

`ifdef BIST_ORA_ABORT_EN
    a_drive(1, 0, 8'h00);
    a_drive(0, 1, 8'h01);
    abort_a = 1'b1; a_drive(0, 1, 8'h80); abort_a = 1'b0;
    a_expect("abort", 8'h01, 1'b1, 1'b0);
`endif

    // Randomized runs on the 13-pattern instance
    for (int r = 0; r < 8; r++) begin
      b_run(r[0], r == 5);
    end
    repeat (3) nx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
